conv2d_rd_feeder: RTL

- Upstream stage of the conv2D compute unit: generates the DMem read stream the compute unit consumes on its rdata/rdata_valid/rdata_ready port.
- Issues WT_DIM*WT_DIM weight reads, then, for each OFM(y, x) in raster order, reads only the non-halo IFM cells of the window in (m, n) nested order.
- Halo cells are never requested; the compute unit zero-fills them itself.
- Buffers in-order memory responses in a small FIFO, with credit-based request throttling so no response is ever dropped.

---
 rtl/conv2d_rd_feeder_pkg.sv | 35 +++
 rtl/conv2d_rd_feeder_fifo.sv | 67 ++++++
 rtl/conv2d_rd_feeder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_rd_feeder_pkg.sv
// conv2d_rd_feeder_pkg
//   Shared definitions for the conv2D read feeder and the compute unit:
//   FSM state encoding, weight-window size helpers and the halo predicate.
//   The compute unit uses the same is_halo() so both sides agree on which
//   window cells are zero-filled instead of read.
package conv2d_rd_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_WT = 2'd1,
        RD_FM = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // WT_SIZE: number of weight words in a WT_DIM x WT_DIM kernel.
    function automatic int wt_size(input int dim);
        return dim * dim;
    endfunction

    // HALF_WT_DIM: offset of the kernel centre from its top-left cell.
    function automatic int half_wt_dim(input int dim);
        return dim >>> 1;
    endfunction

    // A window cell is halo when its IFM coordinate falls outside the map.
    // Once a coordinate is known to be non-negative an unsigned compare
    // against the dimension is exact.
    function automatic logic is_halo(input logic signed [31:0] idx,
                                     input logic signed [31:0] idy,
                                     input logic        [31:0] dim);
        return (idx < 0) || (idy < 0) ||
               ($unsigned(idx) >= dim) || ($unsigned(idy) >= dim);
    endfunction

endpackage

// File: rtl/conv2d_rd_feeder_fifo.sv
// conv2d_rd_feeder_fifo
//   Synchronous FIFO buffering in-order memory responses.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     i_push        write i_push_data (ignored only if full and not popping)
//     i_pop         remove head (ignored when empty)
//     o_pop_data    head entry, zero while empty
//     o_empty       no entries
//     o_count       number of entries, 0..DEPTH
//   Push and pop in the same cycle are both honoured, even when full.
module conv2d_rd_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage needs no reset: it is only visible through o_pop_data,
    // which is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/conv2d_rd_feeder.sv
// conv2d_rd_feeder
//   Generates the DMem read stream for the conv2D compute unit: all weight
//   words first, then for every output pixel in raster order the non-halo
//   IFM cells of its window in (m, n) order. Responses are buffered in a
//   small FIFO; requests are throttled by credits so that responses already
//   requested always have a FIFO slot.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     start                        begin a pass (honoured in IDLE only)
//     idle                         no pass running and FIFO empty
//     fm_dim, wt_base, ifm_base    pass configuration, sampled at start
//     req_addr/req_valid/req_ready DMem read request channel
//     resp_data/resp_valid         in-order DMem responses, no backpressure
//     rdata/rdata_valid/rdata_ready stream to the compute unit
//     o_dbg_state                  current FSM state
//   Handshake: a transfer happens on every clock edge where valid and ready
//   are both high; once valid is raised its payload is held stable and
//   valid stays high until that transfer happens.
module conv2d_rd_feeder
    import conv2d_rd_feeder_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int WT_DIM     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              idle,
    input  logic [31:0]       fm_dim,
    input  logic [AWIDTH-1:0] wt_base,
    input  logic [AWIDTH-1:0] ifm_base,
    output logic [AWIDTH-1:0] req_addr,
    output logic              req_valid,
    input  logic              req_ready,
    input  logic [DWIDTH-1:0] resp_data,
    input  logic              resp_valid,
    output logic [DWIDTH-1:0] rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [1:0]        o_dbg_state
);
    localparam int WT_SIZE = wt_size(WT_DIM);
    localparam int HALF    = half_wt_dim(WT_DIM);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_fm_dim;
    logic [31:0]       r_k;
    logic [31:0]       r_y, r_x, r_m, r_n;
    logic              r_cur_done;
    logic [AWIDTH-1:0] r_wt_base;
    logic [AWIDTH-1:0] r_win_row;   // address of IFM row y-HALF, column 0
    logic [AWIDTH-1:0] r_row_addr;  // address of IFM row y-HALF+m, column 0
    logic              r_req_valid;
    logic [AWIDTH-1:0] r_req_addr;
    logic [CW-1:0]     r_outstanding;

    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_empty;
    logic               w_fire, w_push, w_pop, w_slot_free, w_credit_ok;
    logic [CW:0]        w_used;
    logic signed [31:0] w_idx, w_idy;
    logic               w_halo, w_wt_last, w_fm_last;
    logic               w_wt_step, w_fm_step, w_load;
    logic [AWIDTH-1:0]  w_load_addr;
    logic [AWIDTH-1:0]  w_win_init;

    assign w_fire      = r_req_valid && req_ready;
    // A response arriving with nothing outstanding is stale (issued before
    // a reset) and is dropped.
    assign w_push      = resp_valid && (r_outstanding != '0);
    assign w_pop       = !w_fifo_empty && rdata_ready;
    assign w_slot_free = !r_req_valid || req_ready;

    // Every request loaded into the slot is guaranteed a FIFO entry:
    // outstanding + buffered + the one firing now must leave room for it.
    assign w_used      = {1'b0, r_outstanding} + {1'b0, w_fifo_count} + {{CW{1'b0}}, w_fire};
    assign w_credit_ok = (w_used < (CW+1)'(FIFO_DEPTH));

    assign w_idx     = $signed(r_x + r_n - 32'(HALF));
    assign w_idy     = $signed(r_y + r_m - 32'(HALF));
    assign w_halo    = is_halo(w_idx, w_idy, r_fm_dim);
    assign w_wt_last = (r_k == 32'(WT_SIZE - 1));
    assign w_fm_last = (r_y == r_fm_dim - 32'd1) && (r_x == r_fm_dim - 32'd1) &&
                       (r_m == 32'(WT_DIM - 1)) && (r_n == 32'(WT_DIM - 1));
    assign w_win_init = ifm_base - AWIDTH'(fm_dim) * AWIDTH'(HALF);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (start) w_next_state = RD_WT;
            RD_WT: if (r_cur_done && w_fire)
                       w_next_state = (r_fm_dim == 32'd0) ? DRAIN : RD_FM;
            RD_FM: if (r_cur_done && w_slot_free) w_next_state = DRAIN;
            DRAIN: if ((r_outstanding == '0) && w_fifo_empty) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / cursor strobes ----------------
    // Halo cells advance the cursor without needing the request slot.
    always_comb begin
        idle        = 1'b0;
        w_wt_step   = 1'b0;
        w_fm_step   = 1'b0;
        w_load_addr = r_req_addr;
        case (r_state)
            IDLE:  idle = w_fifo_empty;
            RD_WT: begin
                w_wt_step   = !r_cur_done && w_slot_free && w_credit_ok;
                w_load_addr = r_wt_base + AWIDTH'(r_k);
            end
            RD_FM: begin
                w_fm_step   = !r_cur_done && (w_halo || (w_slot_free && w_credit_ok));
                w_load_addr = r_row_addr + AWIDTH'(w_idx);
            end
            default: ;
        endcase
        w_load = w_wt_step || (w_fm_step && !w_halo);
    end

    // ---------------- cursor ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fm_dim   <= '0;
            r_wt_base  <= '0;
            r_k        <= '0;
            r_y        <= '0;
            r_x        <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_cur_done <= 1'b0;
            r_win_row  <= '0;
            r_row_addr <= '0;
        end else if (r_state == IDLE && start) begin
            r_fm_dim   <= fm_dim;
            r_wt_base  <= wt_base;
            r_k        <= '0;
            r_y        <= '0;
            r_x        <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_cur_done <= 1'b0;
            r_win_row  <= w_win_init;
            r_row_addr <= w_win_init;
        end else if (w_wt_step) begin
            if (w_wt_last) r_cur_done <= 1'b1;
            else           r_k <= r_k + 32'd1;
        end else if (r_state == RD_WT && w_next_state == RD_FM) begin
            r_cur_done <= 1'b0;
        end else if (w_fm_step) begin
            if (w_fm_last) begin
                r_cur_done <= 1'b1;
            end else if (r_n != 32'(WT_DIM - 1)) begin
                r_n <= r_n + 32'd1;
            end else begin
                r_n <= '0;
                if (r_m != 32'(WT_DIM - 1)) begin
                    r_m        <= r_m + 32'd1;
                    r_row_addr <= r_row_addr + AWIDTH'(r_fm_dim);
                end else begin
                    r_m <= '0;
                    if (r_x != r_fm_dim - 32'd1) begin
                        r_x        <= r_x + 32'd1;
                        r_row_addr <= r_win_row;
                    end else begin
                        r_x        <= '0;
                        r_y        <= r_y + 32'd1;
                        r_win_row  <= r_win_row + AWIDTH'(r_fm_dim);
                        r_row_addr <= r_win_row + AWIDTH'(r_fm_dim);
                    end
                end
            end
        end
    end

    // ---------------- request slot and credits ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else if (w_load) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= w_load_addr;
        end else if (w_fire) begin
            r_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_fire, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    conv2d_rd_feeder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DWIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (resp_data),
        .i_pop       (w_pop),
        .o_pop_data  (rdata),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign rdata_valid = !w_fifo_empty;
    assign req_valid   = r_req_valid;
    assign req_addr    = r_req_addr;
    assign o_dbg_state = r_state;

endmodule
